// File: rtl/video_ctrl_sequencer.sv
// Arbitrates two configuration requesters onto the video block control port,
// deferring geometry ops into shadow slots that are flushed at frame start.
module video_ctrl_sequencer #(
  parameter int HOLD_CYCLES = 2,
  parameter int OP_W        = 8
) (
  input  logic            m_axis_vid_aclk,
  input  logic            aresetn,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OP_W-1:0] req0_op,
  input  logic [31:0]     req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OP_W-1:0] req1_op,
  input  logic [31:0]     req1_data,
  input  logic            frame_start,
  input  logic            defer_en,
  output logic [OP_W-1:0] control_op,
  output logic [31:0]     control_data,
  output logic [2:0]      pending,
  output logic            busy
);

  localparam logic [OP_W-1:0] OP_CM  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_DIM = OP_W'(2);
  localparam logic [OP_W-1:0] OP_PAL = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SCL = OP_W'(4);
  localparam logic [OP_W-1:0] OP_VS  = OP_W'(5);
  localparam logic [3:0]      HOLD   = 4'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_FISSUE,
    S_FGAP
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_last_grant;
  logic            r_flush_req;
  logic [2:0]      r_pending;
  logic [2:0]      r_fsel;
  logic [31:0]     r_sh_cm;
  logic [31:0]     r_sh_dim;
  logic [31:0]     r_sh_scl;
  logic [OP_W-1:0] r_op;
  logic [31:0]     r_data;

  logic            w_gnt;
  logic            w_open;
  logic            w_xfer;
  logic [OP_W-1:0] w_op;
  logic [31:0]     w_data;
  logic            w_geo;
  logic            w_known;
  logic [2:0]      w_slot;
  logic            w_defer;
  logic            w_issue;
  logic            w_in_flush;
  logic            w_enter;
  logic [2:0]      w_fsel;
  logic [OP_W-1:0] w_fop;
  logic [31:0]     w_fdata;

  // Both valid: alternate away from the last winner; idle bus favours req0.
  assign w_gnt  = req1_valid && (!req0_valid || !r_last_grant);
  assign w_open = aresetn && (r_state == S_IDLE) && !r_flush_req;
  assign req0_ready = w_open && !w_gnt;
  assign req1_ready = w_open && w_gnt;
  assign w_xfer = w_gnt ? (req1_valid && req1_ready)
                        : (req0_valid && req0_ready);
  assign w_op   = w_gnt ? req1_op : req0_op;
  assign w_data = w_gnt ? req1_data : req0_data;

  always_comb begin
    w_geo   = 1'b0;
    w_known = 1'b0;
    w_slot  = 3'b000;
    unique case (w_op)
      OP_CM:  begin w_geo = 1'b1; w_known = 1'b1; w_slot = 3'b001; end
      OP_DIM: begin w_geo = 1'b1; w_known = 1'b1; w_slot = 3'b010; end
      OP_SCL: begin w_geo = 1'b1; w_known = 1'b1; w_slot = 3'b100; end
      OP_PAL: w_known = 1'b1;
      OP_VS:  w_known = 1'b1;
      default: ;
    endcase
  end

  assign w_defer = w_xfer && w_geo && defer_en;
  assign w_issue = w_xfer && w_known && !w_defer;
  assign w_in_flush = (r_state == S_FISSUE) || (r_state == S_FGAP);

  // Flush order is colormode, dimensions, scale.
  always_comb begin
    w_fsel  = 3'b000;
    w_fop   = '0;
    w_fdata = '0;
    if (r_pending[0]) begin
      w_fsel  = 3'b001;
      w_fop   = OP_CM;
      w_fdata = r_sh_cm;
    end else if (r_pending[1]) begin
      w_fsel  = 3'b010;
      w_fop   = OP_DIM;
      w_fdata = r_sh_dim;
    end else if (r_pending[2]) begin
      w_fsel  = 3'b100;
      w_fop   = OP_SCL;
      w_fdata = r_sh_scl;
    end
  end

  assign w_enter = ((r_state == S_IDLE || r_state == S_GAP) && r_flush_req)
                || (r_state == S_FGAP && r_pending != 3'b000);

  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_flush_req  <= 1'b0;
      r_pending    <= '0;
      r_fsel       <= '0;
      r_sh_cm      <= '0;
      r_sh_dim     <= '0;
      r_sh_scl     <= '0;
      r_op         <= '0;
      r_data       <= '0;
    end else begin
      if (w_xfer)
        r_last_grant <= w_gnt;
      if (frame_start && !w_in_flush &&
          (r_pending != 3'b000 || w_defer))
        r_flush_req <= 1'b1;
      if (w_defer) begin
        r_pending <= r_pending | w_slot;
        if (w_slot[0]) r_sh_cm  <= w_data;
        if (w_slot[1]) r_sh_dim <= w_data;
        if (w_slot[2]) r_sh_scl <= w_data;
      end
      if (w_enter) begin
        r_flush_req <= 1'b0;
        if (w_fsel != 3'b000) begin
          r_state <= S_FISSUE;
          r_fsel  <= w_fsel;
          r_op    <= w_fop;
          r_data  <= w_fdata;
          r_cnt   <= 4'd1;
        end else begin
          r_state <= S_IDLE;
        end
      end else begin
        unique case (r_state)
          S_IDLE: if (w_issue) begin
            r_state <= S_ISSUE;
            r_op    <= w_op;
            r_data  <= w_data;
            r_cnt   <= 4'd1;
          end
          S_ISSUE, S_FISSUE: if (r_cnt == HOLD) begin
            r_op   <= '0;
            r_data <= '0;
            if (r_state == S_FISSUE) begin
              r_pending <= r_pending & ~r_fsel;
              r_state   <= S_FGAP;
            end else begin
              r_state <= S_GAP;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
          S_GAP:  r_state <= S_IDLE;
          S_FGAP: r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign control_op   = r_op;
  assign control_data = r_data;
  assign pending      = r_pending;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_video_ctrl_sequencer.sv
// Directed bench for video_ctrl_sequencer: immediate issue, round robin,
// deferred geometry flush, flush after an issue, unknown ops and reset abort.
module tb_video_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        req0_valid, req0_ready;
  logic [7:0]  req0_op;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [7:0]  req1_op;
  logic [31:0] req1_data;
  logic        frame_start, defer_en;
  logic [7:0]  control_op;
  logic [31:0] control_data;
  logic [2:0]  pending;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  video_ctrl_sequencer #(.HOLD_CYCLES(2), .OP_W(8)) dut (
    .m_axis_vid_aclk(clk),
    .aresetn(aresetn),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_op(req0_op),
    .req0_data(req0_data),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_op(req1_op),
    .req1_data(req1_data),
    .frame_start(frame_start),
    .defer_en(defer_en),
    .control_op(control_op),
    .control_data(control_data),
    .pending(pending),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int i0, i1, k, w, nz;
    logic [7:0]  prev;
    logic [31:0] e;
    bit x0, x1;
    logic [7:0]  fop [6];
    logic [31:0] fdat [6];
    logic [7:0]  aop [5];

    aresetn = 1'b0;
    req0_valid = 0; req0_op = 0; req0_data = 0;
    req1_valid = 0; req1_op = 0; req1_data = 0;
    frame_start = 0; defer_en = 0;
    repeat (3) cyc();
    chk("rst_op", control_op, 0);
    chk("rst_data", control_data, 0);
    chk("rst_pend", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    aresetn = 1'b1;
    #1;
    chk("idle_rdy0", req0_ready, 1);

    // Immediate palette op
    req0_valid = 1; req0_op = 8'd3; req0_data = 32'h05FF0000;
    #1 chk("pal_rdy", req0_ready, 1);
    cyc();
    req0_valid = 0;
    chk("pal_op1", control_op, 3);
    chk("pal_d1", control_data, 32'h05FF0000);
    cyc();
    chk("pal_op2", control_op, 3);
    chk("pal_d2", control_data, 32'h05FF0000);
    cyc();
    chk("pal_gap", control_op, 0);
    chk("pal_gbusy", busy, 1);
    chk("pal_grdy", req0_ready, 0);
    cyc();
    chk("pal_rdy4", req0_ready, 1);
    chk("pal_busy4", busy, 0);

    // Round robin: req0 won last, so req1 goes first
    i0 = 0; i1 = 0; k = 0; prev = 0;
    req0_valid = 1; req0_op = 8'd3; req0_data = 32'hA0000000;
    req1_valid = 1; req1_op = 8'd5; req1_data = 32'hB0000000;
    #1;
    for (int c = 0; c < 120 && k < 8; c++) begin
      if (control_op != 0 && prev == 0) begin
        e = ((k % 2) == 0) ? 32'hB0000000 : 32'hA0000000;
        e = e + 32'(k / 2);
        chk("rr_op", control_op, ((k % 2) == 0) ? 5 : 3);
        chk("rr_data", control_data, e);
        k++;
      end
      prev = control_op;
      x0 = req0_valid && req0_ready;
      x1 = req1_valid && req1_ready;
      cyc();
      if (x0) begin
        i0++;
        if (i0 == 4) req0_valid = 0;
        else req0_data = 32'hA0000000 + 32'(i0);
      end
      if (x1) begin
        i1++;
        if (i1 == 4) req1_valid = 0;
        else req1_data = 32'hB0000000 + 32'(i1);
      end
    end
    chk("rr_count", k, 8);
    repeat (4) cyc();
    chk("rr_idle", busy, 0);

    // Deferred geometry ops, repeat write to the dimensions slot
    defer_en = 1;
    req0_valid = 1; req0_op = 8'd2; req0_data = 32'h01E00280;
    #1 chk("df_rdy1", req0_ready, 1);
    cyc();
    req0_data = 32'h02580320;
    #1 chk("df_rdy2", req0_ready, 1);
    chk("df_noop2", control_op, 0);
    cyc();
    req0_op = 8'd4; req0_data = 32'h3;
    #1 chk("df_rdy3", req0_ready, 1);
    cyc();
    req0_valid = 0;
    chk("df_pend", pending, 3'b110);
    chk("df_noop", control_op, 0);
    chk("df_busy", busy, 0);
    frame_start = 1;
    cyc();
    frame_start = 0;
    w = 0;
    while (control_op == 0 && w < 6) begin
      chk("fl_stall", req0_ready, 0);
      cyc();
      w++;
    end
    chk("fl_start", (w < 6) ? 1 : 0, 1);
    fop  = '{8'd2, 8'd2, 8'd0, 8'd4, 8'd4, 8'd0};
    fdat = '{32'h02580320, 32'h02580320, 0, 32'h3, 32'h3, 0};
    for (int j = 0; j < 6; j++) begin
      chk("fl_op", control_op, fop[j]);
      if (fop[j] != 0) chk("fl_data", control_data, fdat[j]);
      chk("fl_rdy", req0_ready, 0);
      cyc();
    end
    chk("fl_pend", pending, 0);
    chk("fl_busy", busy, 0);
    chk("fl_rdy_end", req0_ready, 1);

    // Frame start during a palette issue, colormode pending, defer dropped
    req0_valid = 1; req0_op = 8'd1; req0_data = 32'h2;
    #1;
    cyc();
    chk("fi_pend", pending, 3'b001);
    defer_en = 0;
    req0_op = 8'd3; req0_data = 32'h11223344;
    #1 chk("fi_rdy", req0_ready, 1);
    cyc();
    req0_valid = 0;
    chk("fi_pal", control_op, 3);
    chk("fi_pald", control_data, 32'h11223344);
    chk("fi_keep", pending, 3'b001);
    frame_start = 1;
    req1_valid = 1; req1_op = 8'd5; req1_data = 32'hDEAD;
    #1 chk("fi_rdy1", req1_ready, 0);
    cyc();
    frame_start = 0;
    aop = '{8'd3, 8'd0, 8'd1, 8'd1, 8'd0};
    for (int j = 0; j < 5; j++) begin
      chk("fi_op", control_op, aop[j]);
      if (aop[j] == 1) chk("fi_cmd", control_data, 32'h2);
      chk("fi_stall", req1_ready, 0);
      if (j == 4) req1_valid = 0;
      cyc();
    end
    chk("fi_pend0", pending, 0);
    chk("fi_idle", busy, 0);
    chk("fi_op0", control_op, 0);

    // Unknown opcode is accepted and dropped
    req0_valid = 1; req0_op = 8'h09; req0_data = 32'hFFFF;
    #1 chk("uk_rdy", req0_ready, 1);
    cyc();
    req0_valid = 0;
    #1;
    chk("uk_op", control_op, 0);
    chk("uk_busy", busy, 0);
    chk("uk_rdy2", req0_ready, 1);
    cyc();
    chk("uk_op2", control_op, 0);

    // Geometry op with deferral off goes out immediately
    req0_valid = 1; req0_op = 8'd2; req0_data = 32'hABCD;
    #1;
    cyc();
    req0_valid = 0;
    chk("gi_op", control_op, 2);
    chk("gi_data", control_data, 32'hABCD);
    chk("gi_pend", pending, 0);
    repeat (3) cyc();
    chk("gi_idle", busy, 0);

    // Deferred scale coinciding with frame start, then reset mid-flush
    defer_en = 1;
    req0_valid = 1; req0_op = 8'd4; req0_data = 32'h7;
    frame_start = 1;
    #1;
    cyc();
    req0_valid = 0;
    frame_start = 0;
    w = 0;
    while (control_op == 0 && w < 6) begin
      cyc();
      w++;
    end
    chk("co_op", control_op, 4);
    chk("co_data", control_data, 32'h7);
    aresetn = 0;
    cyc();
    chk("ra_op", control_op, 0);
    chk("ra_pend", pending, 0);
    chk("ra_busy", busy, 0);
    aresetn = 1;
    nz = 0;
    repeat (6) begin
      if (control_op != 0) nz++;
      cyc();
    end
    chk("ra_noissue", nz, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
